// File: rtl/cpu_bus_bridge_if.sv
// CPU-side request/reply bus: level request strobe held by the core, one-cycle ready pulse back.
interface cpu_bus_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              bus_clk;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_data_ready;

    modport master (
        output bus_clk, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_data_ready
    );

    modport slave (
        input  bus_clk, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_data_ready
    );
endinterface

// File: rtl/cpu_bus_bridge.sv
// Decodes one CPU request at a time to memory (fixed wait), I/O (req/ack with timeout) or open bus.
// Ready pulses 2+MEM_WAIT edges after the request edge for memory; the core holds its request until then.
module cpu_bus_bridge #(
    parameter int                  DATA_W     = 32,
    parameter int                  ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]   MEM_SIZE   = 32'h0001_0000,
    parameter int                  MEM_WAIT   = 0,
    parameter logic [ADDR_W-1:0]   IO_BASE    = 32'hFFFF_0000,
    parameter logic [ADDR_W-1:0]   IO_SIZE    = 32'h0001_0000,
    parameter int                  IO_TIMEOUT = 64,
    parameter logic [DATA_W-1:0]   OPEN_BUS   = 32'hFFFF_FFFF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    cpu_bus_bridge_if.slave        bus_io,
    output logic                   o_mem_en,
    output logic                   o_mem_we,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]      o_mem_wdata,
    input  logic [DATA_W-1:0]      i_mem_rdata,
    output logic                   o_io_req,
    output logic                   o_io_we,
    output logic [15:0]            o_io_addr,
    output logic [DATA_W-1:0]      o_io_wdata,
    input  logic [DATA_W-1:0]      i_io_rdata,
    input  logic                   i_io_ack,
    input  logic                   i_err_clr,
    output logic                   o_bus_err,
    output logic                   o_busy
);
    localparam int              CNT_W    = $clog2(IO_TIMEOUT + 16);
    localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_MEM_ACC, S_MEM_WAIT, S_IO_WAIT, S_RESP, S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rdy_q;
    logic              err_set;

    // Offset arithmetic wraps, so a region ending at the top of the address space decodes correctly.
    logic [ADDR_W-1:0] req_io_off, cap_io_off;
    logic              mem_hit, io_hit;

    assign req_io_off = bus_io.bus_addr - IO_BASE;
    assign cap_io_off = addr_q - IO_BASE;
    assign mem_hit    = bus_io.bus_addr < MEM_SIZE;
    assign io_hit     = req_io_off < IO_SIZE;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rdy_q   <= (state_q == S_RESP);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_io.bus_clk) begin
                    we_d    = bus_io.bus_we;
                    addr_d  = bus_io.bus_addr;
                    wdata_d = bus_io.bus_wdata;
                    cnt_d   = '0;
                    if (mem_hit) begin
                        state_d = S_MEM_ACC;
                    end else if (io_hit) begin
                        state_d = S_IO_WAIT;
                    end else begin
                        state_d = S_RESP;
                        err_set = 1'b1;
                        if (!bus_io.bus_we) rdata_d = OPEN_BUS;
                    end
                end
            end
            S_MEM_ACC: begin
                if (MEM_WAIT == 0) begin
                    if (!we_q) rdata_d = i_mem_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (cnt_q == MEM_LAST) begin
                    if (!we_q) rdata_d = i_mem_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IO_WAIT: begin
                // An ack on the final timeout cycle still completes normally.
                if (i_io_ack) begin
                    if (!we_q) rdata_d = i_io_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == IO_LAST) begin
                    err_set = 1'b1;
                    if (!we_q) rdata_d = OPEN_BUS;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:    state_d = S_RELEASE;
            S_RELEASE: if (!bus_io.bus_clk) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        err_d = err_q;
        if (i_err_clr) err_d = 1'b0;
        if (err_set)   err_d = 1'b1;
    end

    assign bus_io.bus_rdata      = rdata_q;
    assign bus_io.bus_data_ready = rdy_q;
    assign o_mem_en    = (state_q == S_MEM_ACC);
    assign o_mem_we    = (state_q == S_MEM_ACC) && we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_io_req    = (state_q == S_IO_WAIT);
    assign o_io_we     = (state_q == S_IO_WAIT) && we_q;
    assign o_io_addr   = cap_io_off[15:0];
    assign o_io_wdata  = wdata_q;
    assign o_bus_err   = err_q;
    assign o_busy      = (state_q != S_IDLE);
endmodule
